// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between the multicycle controller (master)
// and its surroundings: instruction fetch, datapath and data memory (slave).
interface multicycle_control_if #(
  parameter int OPW = 5
);
  logic           instr_valid;
  logic [OPW-1:0] opcode;
  logic           halt_req;
  logic           alu_branch;
  logic           mem_ack;

  logic           instr_ready;
  logic           pc_en;
  logic           jump_en;
  logic [1:0]     immOrLUT;
  logic [1:0]     imm_ctr;
  logic           ALU_in2_ctr;
  logic           numBits;
  logic           RXOR;
  logic           regfile_wr_ctr;
  logic           regfile_dat_ctr;
  logic           RegWrite;
  logic           MemWrite;
  logic           mem_req;
  logic           doSWAP;
  logic           swap_phase;
  logic           busy;
  logic           illegal;
  logic           fault;
  logic           done;

  modport master (
    input  instr_valid, opcode, halt_req, alu_branch, mem_ack,
    output instr_ready, pc_en, jump_en, immOrLUT, imm_ctr, ALU_in2_ctr,
           numBits, RXOR, regfile_wr_ctr, regfile_dat_ctr, RegWrite,
           MemWrite, mem_req, doSWAP, swap_phase, busy, illegal, fault, done
  );

  modport slave (
    output instr_valid, opcode, halt_req, alu_branch, mem_ack,
    input  instr_ready, pc_en, jump_en, immOrLUT, imm_ctr, ALU_in2_ctr,
           numBits, RXOR, regfile_wr_ctr, regfile_dat_ctr, RegWrite,
           MemWrite, mem_req, doSWAP, swap_phase, busy, illegal, fault, done
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: latches an opcode in FETCH and steps it
// through DECODE/EXEC/MEM/WB (or SWAP2), with memory timeout and halt states.
module multicycle_control #(
  parameter int OPW     = 5,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_SWAP2, S_HALT, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_LOAD, C_STORE, C_BRANCH, C_SWAP
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic       legal;
    logic       in2;
    logic       imm;
    logic       num_bits;
    logic       rxor;
    logic       wr_ctr;
    logic [1:0] target;
    logic       jump_always;
  } dec_t;

  state_t           state, state_nx;
  logic [OPW-1:0]   op_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic             illegal_q;
  logic             timeout_hit;
  dec_t             dec;

  assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Instruction class decode of the latched opcode.
  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred.
    dec       = '0;
    dec.legal = 1'b1;
    case (op_q[4:0])
      5'b01000, 5'b01001, 5'b00100, 5'b01010, 5'b01011,
      5'b01100, 5'b01101, 5'b00101: dec.cls = C_ALU;
      5'b11000, 5'b11001, 5'b11100, 5'b11101, 5'b11110: begin
        dec.cls = C_ALU;
        dec.in2 = 1'b1;
        dec.imm = 1'b1;
      end
      5'b00111: begin
        dec.cls      = C_ALU;
        dec.in2      = 1'b1;
        dec.imm      = 1'b1;
        dec.num_bits = 1'b1;
        dec.wr_ctr   = 1'b1;
      end
      5'b01110, 5'b01111: begin
        dec.cls  = C_ALU;
        dec.rxor = 1'b1;
      end
      5'b10000, 5'b10110, 5'b11010, 5'b11011: dec.cls = C_LOAD;
      5'b10001, 5'b10111: dec.cls = C_STORE;
      5'b00110: begin
        dec.cls = C_STORE;
        dec.in2 = 1'b1;
        dec.imm = 1'b1;
      end
      5'b00010: begin
        dec.cls         = C_BRANCH;
        dec.target      = 2'b10;
        dec.jump_always = 1'b1;
      end
      5'b00001: begin
        dec.cls         = C_BRANCH;
        dec.target      = 2'b01;
        dec.jump_always = 1'b1;
      end
      5'b00011: begin
        dec.cls    = C_BRANCH;
        dec.target = 2'b10;
      end
      5'b11111: dec.cls = C_SWAP;
      5'b00000: dec.cls = C_NOP;
      default:  dec.legal = 1'b0;
    endcase
    // Illegal opcodes, including any with upper bits set, run as a plain NOP.
    if (!dec.legal || ((op_q >> 5) != '0)) dec = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      tmo_cnt   <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state == S_FETCH && !bus.halt_req && bus.instr_valid) op_q <= bus.opcode;
      if (state == S_DECODE && !dec.legal) illegal_q <= 1'b1;
      if (state != S_MEM)    tmo_cnt <= '0;
      else if (!bus.mem_ack) tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: begin
        if (bus.halt_req)         state_nx = S_HALT;
        else if (bus.instr_valid) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        case (dec.cls)
          C_ALU:            state_nx = S_WB;
          C_LOAD, C_STORE:  state_nx = S_MEM;
          C_SWAP:           state_nx = S_SWAP2;
          default:          state_nx = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ack)  state_nx = (dec.cls == C_LOAD) ? S_WB : S_FETCH;
        else if (timeout_hit) state_nx = S_FAULT;
      end
      S_WB, S_SWAP2: state_nx = S_FETCH;
      default:       state_nx = state;
    endcase
  end

  always_comb begin
    bus.instr_ready     = (state == S_FETCH);
    bus.busy            = (state == S_DECODE) || (state == S_EXEC) || (state == S_MEM) ||
                          (state == S_WB) || (state == S_SWAP2);
    bus.done            = (state == S_HALT);
    bus.fault           = (state == S_FAULT);
    bus.illegal         = illegal_q;
    bus.pc_en           = 1'b0;
    bus.jump_en         = 1'b0;
    bus.immOrLUT        = 2'b00;
    bus.RegWrite        = 1'b0;
    bus.MemWrite        = 1'b0;
    bus.mem_req         = 1'b0;
    bus.doSWAP          = 1'b0;
    bus.swap_phase      = 1'b0;
    // Class selects hold from DECODE until the instruction retires.
    bus.ALU_in2_ctr     = bus.busy && dec.in2;
    bus.imm_ctr         = (bus.busy && dec.imm) ? 2'b10 : 2'b00;
    bus.numBits         = bus.busy && dec.num_bits;
    bus.RXOR            = bus.busy && dec.rxor;
    bus.regfile_wr_ctr  = bus.busy && dec.wr_ctr;
    bus.regfile_dat_ctr = bus.busy && (dec.cls == C_LOAD);
    case (state)
      S_EXEC: begin
        case (dec.cls)
          C_BRANCH: begin
            bus.pc_en    = 1'b1;
            bus.immOrLUT = dec.target;
            bus.jump_en  = dec.jump_always || bus.alu_branch;
          end
          C_SWAP: begin
            bus.doSWAP   = 1'b1;
            bus.RegWrite = 1'b1;
          end
          C_NOP:   bus.pc_en = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.MemWrite = (dec.cls == C_STORE);
        bus.pc_en    = (dec.cls == C_STORE) && bus.mem_ack;
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.pc_en    = 1'b1;
      end
      S_SWAP2: begin
        bus.doSWAP     = 1'b1;
        bus.swap_phase = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.pc_en      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised successor to the single-cycle control decoder.
- Latches a fetched opcode and sequences it through FETCH/DECODE/EXEC/MEM/WB states.
- Drives the same datapath control signals plus a memory request/acknowledge handshake, a PC-advance strobe, a two-phase SWAP, a memory timeout and halt handling.
- Sits between instruction fetch, the register file/ALU datapath and data memory.

Parameters:
- OPW, 5, opcode width; encodings below occupy the low 5 bits, upper bits must be 0 or the opcode is illegal.
- TIMEOUT, 15, max cycles MEM waits for mem_ack before faulting (>=1).
- CNT_W, 4, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  opcode input valid this cycle.
- opcode  in  OPW  instruction opcode.
- halt_req  in  1  stop request, sampled in FETCH only.
- alu_branch  in  1  ALU equality result, sampled in EXEC.
- mem_ack  in  1  memory completed request.
- instr_ready  out  1  high in FETCH.
- pc_en  out  1  one-cycle PC advance/load strobe.
- jump_en  out  1  PC loads branch target (only coincident with pc_en).
- immOrLUT  out  2  branch target source: 01 LUT, 10 immediate.
- imm_ctr  out  2  immediate mode: 10 unsigned.
- ALU_in2_ctr, numBits, RXOR, regfile_wr_ctr, regfile_dat_ctr  out  1 each  datapath selects.
- RegWrite  out  1  register write enable.
- MemWrite  out  1  store qualifier.
- mem_req  out  1  memory request.
- doSWAP  out  1  swap active.
- swap_phase  out  1  SWAP phase 0/1.
- busy  out  1  not in FETCH/HALT/FAULT.
- illegal  out  1  sticky illegal-opcode flag.
- fault  out  1  memory timeout, sticky.
- done  out  1  halted.

Behaviour:
- Reset: state FETCH. Every output 0 except instr_ready=1. Opcode register, timeout counter, illegal, fault and done are cleared. Reset mid-MEM drops mem_req on the next cycle; no pc_en is issued.
- FETCH:
  - halt_req=1 -> HALT. halt_req has priority over instr_valid.
  - Otherwise instr_valid=1 latches the opcode -> DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle -> EXEC. Class selects are driven from the latched opcode from DECODE until the instruction ends.
- ALU class:
  - ADD 01000, SUB 01001, MOV 00100, AND 01010, OR 01011, SHL 01100, SHR 01101: no immediate.
  - ADDI 11000, MOVI 11001, SHLI 11100, SHRI 11101, ROTL 11110: ALU_in2_ctr=1, imm_ctr=10.
  - BITMASK 00111: as the immediate ops, plus numBits=1 and regfile_wr_ctr=1.
  - XOR_ADD 01110, XOR 01111: RXOR=1.
  - SLT 00101.
  - Sequence EXEC -> WB. In WB, RegWrite=1 and pc_en=1 for one cycle -> FETCH. Total 4 cycles.
- Load class (LB 10000, LTB 10110, LLHB 11010, LUHB 11011):
  - EXEC -> MEM. mem_req=1 until mem_ack, then -> WB.
  - WB: regfile_dat_ctr=1, RegWrite=1, pc_en=1.
- Store class (SB 10001, STB 10111, STBI 00110; STBI also sets imm_ctr=10, ALU_in2_ctr=1):
  - EXEC -> MEM with mem_req=1 and MemWrite=1.
  - In the cycle mem_ack=1: pc_en=1 -> FETCH. No RegWrite.
- Branch class (B 00010, B_LOOKUP 00001, BEQ 00011):
  - In EXEC: pc_en=1. B_LOOKUP sets immOrLUT=01; B and BEQ set immOrLUT=10.
  - jump_en=1 for B and B_LOOKUP, and for BEQ only when alu_branch=1. BEQ with alu_branch=0 falls through.
  - -> FETCH. Total 3 cycles.
- SWAP 11111:
  - EXEC: doSWAP=1, swap_phase=0, RegWrite=1.
  - -> SWAP2: doSWAP=1, swap_phase=1, RegWrite=1, pc_en=1.
  - -> FETCH.
- NOP 00000: EXEC pc_en=1 -> FETCH.
- Illegal opcode (any other low-5 value, e.g. 10010, 10011, 10100, 10101, 11110 excluded; or nonzero upper bits):
  - Executes as NOP and sets illegal=1, sticky until reset.
- MEM timeout:
  - The counter clears on MEM entry and increments each MEM cycle without mem_ack.
  - If mem_ack is absent on the TIMEOUT-th cycle -> FAULT. fault=1, mem_req=0, no pc_en. FAULT is held until reset.
  - mem_ack on exactly the TIMEOUT-th cycle completes normally.
- mem_ack outside MEM is ignored.
- HALT: done=1, instr_ready=0. Held until reset.
- Invariants:
  - pc_en fires exactly once per completed instruction.
  - RegWrite and MemWrite are never both high.
  - busy=1 in DECODE, EXEC, MEM, WB and SWAP2.

Test Plan:
- Reset, then ADDI 11000 with instr_valid -> DECODE, EXEC, WB. WB cycle (cycle 4) shows RegWrite=1, pc_en=1, ALU_in2_ctr=1, imm_ctr=10. Back in FETCH at cycle 5.
- LB 10000 with mem_ack delayed 3 cycles -> mem_req high exactly 3 MEM cycles, then WB with regfile_dat_ctr=1, RegWrite=1. 10000 with ack after 3 cycles and no timeout.
- BEQ 00011 twice: alu_branch=1 -> jump_en=1, immOrLUT=10; alu_branch=0 -> pc_en=1, jump_en=0. B_LOOKUP 00001 -> jump_en=1, immOrLUT=01.
- SWAP 11111 -> two consecutive doSWAP cycles with swap_phase 0 then 1. pc_en only on the second.
- SB 10001 with mem_ack never asserted and TIMEOUT=15 -> fault=1 after 15 MEM cycles, mem_req=0. Apply reset -> fault=0, instr_ready=1.
- Opcode 10010 -> illegal=1, pc_en once, no RegWrite. Then halt_req with instr_valid in FETCH -> done=1 and the opcode is not latched.
